// File: rtl/reduction_table_pkg.sv
// Shared flit/entry layout and reduction op-codes for the allreduce datapath.
// Flit: {valid, dst, src, rank, contextId, tag, algtype, op, payload}.
package reduction_table_pkg;

  localparam int FlitWidth           = 82;
  localparam int ChildrenWidth       = 3;
  localparam int PacketWidth         = FlitWidth + ChildrenWidth;
  localparam int ReductionTableWidth = 91;

  localparam int ValidBitPos    = 81;
  localparam int DstPos         = 72;
  localparam int DstWidth       = 9;
  localparam int SrcPos         = 63;
  localparam int SrcWidth       = 9;
  localparam int RankPos        = 54;
  localparam int RankWidth      = 9;
  localparam int ContextIdPos   = 46;
  localparam int ContextIdWidth = 8;
  localparam int TagPos         = 38;
  localparam int TagWidth       = 8;
  localparam int AlgTypePos     = 36;
  localparam int AlgTypeWidth   = 2;
  localparam int opPos          = 32;
  localparam int OpWidth        = 4;
  localparam int PayloadPos     = 0;
  localparam int PayloadWidth   = 32;
  localparam int ChildrenPos    = 82;

  // contextId and tag are adjacent, so the key is one contiguous slice
  localparam int KeyPos   = TagPos;
  localparam int KeyWidth = ContextIdWidth + TagWidth;

  localparam int LeafBit        = 90;
  localparam int ExtraWaitBit   = 89;
  localparam int WaitCountPos   = 85;
  localparam int WaitCountWidth = 4;

  typedef logic [ReductionTableWidth-1:0] entry_t;

  typedef enum logic [OpWidth-1:0] {
    OP_SUM = 4'b0000,
    OP_MAX = 4'b0001,
    OP_MIN = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101
  } reduce_op_e;

  typedef enum logic [1:0] {
    ENT_FREE,
    ENT_COLLECT,
    ENT_WAIT,
    ENT_READY
  } entry_state_e;

  function automatic entry_state_e entry_state(input entry_t e);
    if (!e[ValidBitPos])                            return ENT_FREE;
    if (!e[ExtraWaitBit])                           return ENT_COLLECT;
    if (e[WaitCountPos +: WaitCountWidth] != '0)    return ENT_WAIT;
    return ENT_READY;
  endfunction

endpackage

// File: rtl/reduction_table_alu.sv
// Combinational 32-bit unsigned reduction operator; unknown op-codes keep the
// accumulated value so a malformed contribution cannot corrupt the result.
module reduce_alu
  import reduction_table_pkg::*;
(
  input  logic [OpWidth-1:0]      op,
  input  logic [PayloadWidth-1:0] a,
  input  logic [PayloadWidth-1:0] b,
  output logic [PayloadWidth-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_SUM:  result = a + b;
      OP_MAX:  result = (a > b) ? a : b;
      OP_MIN:  result = (a < b) ? a : b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/reduction_table.sv
// Associative reduction table: merges contributions sharing (contextId, tag),
// counts down a modelled adder latency, then emits one reduced flit per cycle.
module reduction_table
  import reduction_table_pkg::*;
#(
  parameter int ReductionTableSize = 6,
  parameter int AdderLatency       = 14,
  parameter int DropCntWidth       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PacketWidth-1:0]  packetIn,
  output logic [FlitWidth-1:0]    packetOut,
  output logic                    overflow,
  output logic [DropCntWidth-1:0] drop_count
);

  localparam int IdxW = (ReductionTableSize > 1) ? $clog2(ReductionTableSize) : 1;
  localparam logic [WaitCountWidth-1:0] WaitInit = WaitCountWidth'(AdderLatency);

  function automatic logic [DropCntWidth-1:0] sat_inc(input logic [DropCntWidth-1:0] v);
    return (&v) ? v : v + DropCntWidth'(1);
  endfunction

  entry_t       table_q [ReductionTableSize];
  entry_state_e st      [ReductionTableSize];

  logic                     in_vld_p0;
  logic [KeyWidth-1:0]      in_key_p0;
  logic                     hit_found, free_found, rdy_found;
  logic [IdxW-1:0]          hit_idx, free_idx, rdy_idx;
  entry_t                   hit_entry, hit_next, alloc_next;
  logic [ChildrenWidth-1:0] children_dec;
  logic [PayloadWidth-1:0]  alu_result;

  assign in_vld_p0 = packetIn[ValidBitPos];
  assign in_key_p0 = packetIn[KeyPos +: KeyWidth];

  // ---- stage p0: table search (descending loop leaves the lowest index) ----
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = ReductionTableSize - 1; i >= 0; i--) begin
      st[i] = entry_state(table_q[i]);
      if (in_vld_p0 && st[i] == ENT_COLLECT &&
          table_q[i][KeyPos +: KeyWidth] == in_key_p0) begin
        hit_found = 1'b1;
        hit_idx   = IdxW'(i);
      end
      if (st[i] == ENT_FREE) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (st[i] == ENT_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = IdxW'(i);
      end
    end
  end

  assign hit_entry = table_q[hit_idx];

  reduce_alu u_alu (
    .op     (hit_entry[opPos +: OpWidth]),
    .a      (hit_entry[PayloadPos +: PayloadWidth]),
    .b      (packetIn[PayloadPos +: PayloadWidth]),
    .result (alu_result)
  );

  // Only payload and children change on a hit; header stays from the first packet.
  always_comb begin
    children_dec = hit_entry[ChildrenPos +: ChildrenWidth] - ChildrenWidth'(1);
    hit_next     = hit_entry;
    hit_next[PayloadPos +: PayloadWidth]   = alu_result;
    hit_next[ChildrenPos +: ChildrenWidth] = children_dec;
    if (children_dec == '0) begin
      hit_next[ExtraWaitBit]                   = 1'b1;
      hit_next[WaitCountPos +: WaitCountWidth] = WaitInit;
    end
  end

  always_comb begin
    alloc_next                    = '0;
    alloc_next[PacketWidth-1:0]   = packetIn;
    if (packetIn[ChildrenPos +: ChildrenWidth] == '0) begin
      alloc_next[LeafBit]      = 1'b1;
      alloc_next[ExtraWaitBit] = 1'b1;
    end
  end

  // ---- stage p1: table update and emission register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ReductionTableSize; i++) table_q[i] <= '0;
      packetOut  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      packetOut <= rdy_found ? table_q[rdy_idx][FlitWidth-1:0] : '0;
      if (in_vld_p0 && !hit_found && !free_found) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      for (int i = 0; i < ReductionTableSize; i++) begin
        if (rdy_found && rdy_idx == IdxW'(i)) begin
          table_q[i] <= '0;
        end else if (hit_found && hit_idx == IdxW'(i)) begin
          table_q[i] <= hit_next;
        end else if (in_vld_p0 && !hit_found && free_found && free_idx == IdxW'(i)) begin
          table_q[i] <= alloc_next;
        end else if (st[i] == ENT_WAIT) begin
          table_q[i][WaitCountPos +: WaitCountWidth] <=
            table_q[i][WaitCountPos +: WaitCountWidth] - WaitCountWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reduction_table.sv
// Randomised bench for reduction_table: folds each key's contributions with a
// reference reducer and predicts emission time from the adder latency.
module tb_reduction_table;

  localparam int Lat = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [84:0] packetIn;
  logic [81:0] packetOut;
  logic        overflow;
  logic [7:0]  drop_count;

  int tests_run = 0;
  int fails     = 0;
  int edge_n    = 0;
  int last_edge = 0;

  logic [81:0] outq_f [$];
  int          outq_e [$];

  always #5 clk = ~clk;

  reduction_table #(
    .ReductionTableSize (6),
    .AdderLatency       (Lat),
    .DropCntWidth       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .packetIn   (packetIn),
    .packetOut  (packetOut),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk) begin
    #1;
    if (packetOut[81] === 1'b1) begin
      outq_f.push_back(packetOut);
      outq_e.push_back(edge_n);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return (a >= b) ? a : b;
      4'd2:    return (a <= b) ? a : b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [84:0] mk_pkt(input logic [2:0] ch, input logic [7:0] ctx, input logic [7:0] tag,
                                         input logic [3:0] op, input logic [31:0] pl);
    logic [8:0] dst, src, rank;
    logic [1:0] alg;
    dst  = 9'($urandom);
    src  = 9'($urandom);
    rank = 9'($urandom);
    alg  = 2'($urandom);
    return {ch, 1'b1, dst, src, rank, ctx, tag, alg, op, pl};
  endfunction

  function automatic logic [31:0] rand_pl();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
  endfunction

  task automatic send(input logic [84:0] p);
    @(negedge clk);
    packetIn  = p;
    last_edge = edge_n + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      packetIn = '0;
    end
  endtask

  task automatic idle_until(input int target);
    while (edge_n + 2 < target) begin
      @(negedge clk);
      packetIn = '0;
    end
  endtask

  task automatic get_out(input int deadline, output logic [81:0] f, output int e);
    while (outq_f.size() == 0 && edge_n < deadline) begin
      @(negedge clk);
      packetIn = '0;
    end
    if (outq_f.size() != 0) begin
      f = outq_f.pop_front();
      e = outq_e.pop_front();
    end else begin
      f = '0;
      e = -1;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    packetIn = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (packetOut !== 82'd0) begin fails++; $display("FAIL reset_packetOut: got %h expected 0", packetOut); end
    tests_run++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests_run++;
    if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_leaf();
    logic [84:0] p;
    logic [81:0] f;
    int e;
    p = mk_pkt(3'd0, 8'd1, 8'd5, 4'd0, 32'd7);
    send(p);
    get_out(last_edge + 4, f, e);
    tests_run++;
    if (f !== p[81:0]) begin fails++; $display("FAIL leaf_flit: got %h expected %h", f, p[81:0]); end
    tests_run++;
    if (e !== last_edge + 1) begin fails++; $display("FAIL leaf_latency: got edge %0d expected %0d", e, last_edge + 1); end
    idle(3);
    tests_run++;
    if (outq_f.size() != 0) begin fails++; $display("FAIL leaf_single: got %0d extra outputs expected 0", outq_f.size()); end
  endtask

  task automatic test_sum4();
    logic [84:0] first;
    logic [81:0] f;
    int e;
    first = mk_pkt(3'd3, 8'h22, 8'h33, 4'd0, 32'd10);
    send(first);
    send(mk_pkt(3'd0, 8'h22, 8'h33, 4'd0, 32'd20));
    send(mk_pkt(3'd0, 8'h22, 8'h33, 4'd0, 32'd30));
    send(mk_pkt(3'd0, 8'h22, 8'h33, 4'd0, 32'd40));
    get_out(last_edge + Lat + 4, f, e);
    tests_run++;
    if (f !== {first[81:32], 32'd100}) begin fails++; $display("FAIL sum4_flit: got %h expected %h", f, {first[81:32], 32'd100}); end
    tests_run++;
    if (e !== last_edge + Lat + 1) begin fails++; $display("FAIL sum4_latency: got edge %0d expected %0d", e, last_edge + Lat + 1); end
    idle(Lat);
    tests_run++;
    if (outq_f.size() != 0) begin fails++; $display("FAIL sum4_one_cycle: got %0d extra outputs expected 0", outq_f.size()); end
  endtask

  task automatic test_op_boundaries();
    logic [3:0]  ops [3];
    logic [31:0] bs  [3];
    logic [31:0] exp [3];
    logic [84:0] first;
    logic [81:0] f;
    int e;
    ops = '{4'd1, 4'd2, 4'd0};
    bs  = '{32'd3, 32'd3, 32'd2};
    exp = '{32'hFFFF_FFFF, 32'd3, 32'd1};
    for (int k = 0; k < 3; k++) begin
      first = mk_pkt(3'd1, 8'h60, 8'(k), ops[k], 32'hFFFF_FFFF);
      send(first);
      send(mk_pkt(3'd0, 8'h60, 8'(k), 4'd7, bs[k]));
      get_out(last_edge + Lat + 4, f, e);
      tests_run++;
      if (f !== {first[81:32], exp[k]}) begin fails++; $display("FAIL op_boundary_%0d: got %h expected %h", k, f, {first[81:32], exp[k]}); end
      tests_run++;
      if (e !== last_edge + Lat + 1) begin fails++; $display("FAIL op_boundary_latency_%0d: got edge %0d expected %0d", k, e, last_edge + Lat + 1); end
    end
  endtask

  task automatic test_random_groups();
    logic [84:0] first;
    logic [81:0] f;
    logic [7:0]  ctx, tag;
    logic [3:0]  op;
    logic [31:0] pl, acc;
    int n, e;
    for (int g = 0; g < 10; g++) begin
      ctx   = 8'($urandom);
      tag   = 8'($urandom);
      op    = 4'($urandom_range(0, 15));
      n     = int'($urandom_range(1, 4));
      pl    = rand_pl();
      acc   = pl;
      first = mk_pkt(3'(n), ctx, tag, op, pl);
      send(first);
      for (int k = 0; k < n; k++) begin
        idle(int'($urandom_range(0, 2)));
        pl  = rand_pl();
        acc = alu_ref(op, acc, pl);
        send(mk_pkt(3'($urandom), ctx, tag, 4'($urandom), pl));
      end
      get_out(last_edge + Lat + 4, f, e);
      tests_run++;
      if (f !== {first[81:32], acc}) begin fails++; $display("FAIL random_group_%0d op=%0d n=%0d: got %h expected %h", g, op, n, f, {first[81:32], acc}); end
      tests_run++;
      if (e !== last_edge + Lat + 1) begin fails++; $display("FAIL random_latency_%0d: got edge %0d expected %0d", g, e, last_edge + Lat + 1); end
    end
    idle(3);
    tests_run++;
    if (outq_f.size() != 0) begin fails++; $display("FAIL random_extra: got %0d extra outputs expected 0", outq_f.size()); end
  endtask

  task automatic test_interleaved();
    logic [84:0] a1, b1, lf;
    logic [31:0] pa2, pb2;
    logic [81:0] f;
    int e, e2;
    pa2 = $urandom;
    pb2 = $urandom;
    a1  = mk_pkt(3'd1, 8'd0, 8'd1, 4'd0, $urandom);
    b1  = mk_pkt(3'd1, 8'd0, 8'd2, 4'd5, $urandom);
    lf  = mk_pkt(3'd0, 8'd0, 8'd3, 4'd0, $urandom);
    send(a1);
    send(b1);
    send(mk_pkt(3'd1, 8'd0, 8'd1, 4'd2, pa2));
    e2 = last_edge;
    send(mk_pkt(3'd1, 8'd0, 8'd2, 4'd1, pb2));
    idle_until(e2 + Lat);
    send(lf);
    get_out(e2 + Lat + 4, f, e);
    tests_run++;
    if (f !== {a1[81:32], alu_ref(4'd0, a1[31:0], pa2)} || e !== e2 + Lat + 1) begin
      fails++; $display("FAIL interleave_a: got %h at %0d expected %h at %0d", f, e, {a1[81:32], alu_ref(4'd0, a1[31:0], pa2)}, e2 + Lat + 1);
    end
    get_out(e2 + Lat + 5, f, e);
    tests_run++;
    if (f !== {b1[81:32], alu_ref(4'd5, b1[31:0], pb2)} || e !== e2 + Lat + 2) begin
      fails++; $display("FAIL interleave_b: got %h at %0d expected %h at %0d", f, e, {b1[81:32], alu_ref(4'd5, b1[31:0], pb2)}, e2 + Lat + 2);
    end
    get_out(e2 + Lat + 6, f, e);
    tests_run++;
    if (f !== lf[81:0] || e !== e2 + Lat + 3) begin
      fails++; $display("FAIL interleave_leaf_order: got %h at %0d expected %h at %0d", f, e, lf[81:0], e2 + Lat + 3);
    end
  endtask

  task automatic test_overflow();
    logic [84:0] k0, nk;
    logic [31:0] p2, pn;
    logic [81:0] f;
    int e, ec;
    k0 = mk_pkt(3'd1, 8'h40, 8'd0, 4'd0, $urandom);
    send(k0);
    for (int i = 1; i < 6; i++) send(mk_pkt(3'd1, 8'h40, 8'(i), 4'd0, $urandom));
    idle(1);
    tests_run++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL overflow_before_full: got %b expected 0", overflow); end
    send(mk_pkt(3'd1, 8'h40, 8'd6, 4'd0, $urandom));
    idle(1);
    tests_run++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    tests_run++;
    if (drop_count !== 8'd1) begin fails++; $display("FAIL drop_count_one: got %0d expected 1", drop_count); end
    for (int i = 0; i < 300; i++) send(mk_pkt(3'd1, 8'h41, 8'(i), 4'd0, $urandom));
    idle(1);
    tests_run++;
    if (drop_count !== 8'hFF) begin fails++; $display("FAIL drop_count_saturate: got %0d expected 255", drop_count); end
    p2 = $urandom;
    send(mk_pkt(3'd0, 8'h40, 8'd0, 4'd3, p2));
    ec = last_edge;
    get_out(ec + Lat + 4, f, e);
    tests_run++;
    if (f !== {k0[81:32], k0[31:0] + p2} || e !== ec + Lat + 1) begin
      fails++; $display("FAIL overflow_complete: got %h at %0d expected %h at %0d", f, e, {k0[81:32], k0[31:0] + p2}, ec + Lat + 1);
    end
    nk = mk_pkt(3'd1, 8'h42, 8'd0, 4'd4, $urandom);
    pn = $urandom;
    idle_until(ec + Lat + 2);
    send(nk);
    send(mk_pkt(3'd0, 8'h42, 8'd0, 4'd0, pn));
    get_out(last_edge + Lat + 4, f, e);
    tests_run++;
    if (f !== {nk[81:32], nk[31:0] | pn} || e !== last_edge + Lat + 1) begin
      fails++; $display("FAIL overflow_realloc: got %h at %0d expected %h at %0d", f, e, {nk[81:32], nk[31:0] | pn}, last_edge + Lat + 1);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [84:0] lf;
    logic [81:0] f;
    int e, ew;
    send(mk_pkt(3'd1, 8'h50, 8'd1, 4'd0, $urandom));
    send(mk_pkt(3'd0, 8'h50, 8'd1, 4'd0, $urandom));
    ew = last_edge;
    idle_until(ew + 6);
    @(negedge clk);
    packetIn = '0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(Lat + 6);
    tests_run++;
    if (outq_f.size() != 0) begin fails++; $display("FAIL reset_wait_emission: got %0d outputs expected 0", outq_f.size()); end
    tests_run++;
    if (packetOut !== 82'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      fails++; $display("FAIL reset_wait_outputs: got %h/%b/%0d expected 0/0/0", packetOut, overflow, drop_count);
    end
    lf = mk_pkt(3'd0, 8'h40, 8'd1, 4'd0, $urandom);
    send(lf);
    get_out(last_edge + 4, f, e);
    tests_run++;
    if (f !== lf[81:0] || e !== last_edge + 1) begin
      fails++; $display("FAIL reset_fresh_leaf: got %h at %0d expected %h at %0d", f, e, lf[81:0], last_edge + 1);
    end
  endtask

  initial begin
    test_reset();
    test_leaf();
    test_sum4();
    test_op_boundaries();
    test_random_groups();
    test_interleaved();
    test_overflow();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
